// File: rtl/seek_controller.sv
// seek_controller: converts absolute seek / recalibrate commands into
// step-controller control-byte writes and tracks the believed head position.
// RESET is shared with the step controller at the system level, so both
// blocks return to idle together.
module seek_controller #(
    parameter int MAX_TRACK    = 83,
    parameter int RECAL_PASSES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_SEEK,
    input  logic        CMD_RECAL,
    input  logic [7:0]  TARGET_TRACK,
    input  logic [15:0] SETTLE_CNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [7:0]  CUR_TRACK,
    output logic        TRACK_VALID,
    output logic [7:0]  SC_CTLBYTE,
    output logic        SC_WRITE,
    input  logic        SC_IS_STEPPING,
    input  logic        SC_TRACK0_HIT
);
    typedef enum logic [2:0] {
        S_IDLE, S_PLAN, S_ISSUE, S_ARM, S_WAIT, S_CHECK, S_SETTLE, S_FINISH
    } state_t;

    localparam logic [7:0] MAX_T  = 8'(MAX_TRACK);
    localparam logic [7:0] PASSES = 8'(RECAL_PASSES);

    // A single burst can cover at most 128 steps (7-bit field plus one).
    function automatic logic [7:0] burst_len(input logic [7:0] rem);
        return (rem > 8'd128) ? 8'd128 : rem;
    endfunction

    state_t      state_q, state_d;
    logic        recal_q, recal_d;     // currently running recalibrate bursts
    logic        seek_q, seek_d;       // command is a seek (seek follows an implicit recal)
    logic        moved_q, moved_d;     // head already moved during this command
    logic [7:0]  pass_q, pass_d;       // recalibrate bursts already issued minus one
    logic [7:0]  target_q, target_d;
    logic [15:0] settle_q, settle_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rem_q, rem_d;         // steps still to go for the seek
    logic        dir_q, dir_d;         // 1 = outward
    logic [7:0]  n_q, n_d;             // steps in the burst in flight
    logic [7:0]  cur_q, cur_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [7:0]  ctl_q, ctl_d;
    logic        write_q, write_d;

    logic        dir_c;
    logic [7:0]  diff_c, plan_n_c, rem_left_c, next_n_c, step_cur_c;
    logic [6:0]  plan_field_c, next_field_c;

    assign dir_c        = target_q < cur_q;
    assign diff_c       = dir_c ? (cur_q - target_q) : (target_q - cur_q);
    assign plan_n_c     = burst_len(diff_c);
    assign plan_field_c = 7'(plan_n_c - 8'd1);
    assign rem_left_c   = rem_q - n_q;
    assign next_n_c     = burst_len(rem_left_c);
    assign next_field_c = 7'(next_n_c - 8'd1);
    assign step_cur_c   = dir_q ? (cur_q - n_q) : (cur_q + n_q);

    // Next-state and datapath updates for the command sequencer.
    always_comb begin
        state_d  = state_q;
        recal_d  = recal_q;
        seek_d   = seek_q;
        moved_d  = moved_q;
        pass_d   = pass_q;
        target_d = target_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        n_d      = n_q;
        cur_d    = cur_q;
        valid_d  = valid_q;
        error_d  = error_q;
        ctl_d    = ctl_q;
        case (state_q)
            S_IDLE: begin
                if (CMD_RECAL || CMD_SEEK) begin
                    error_d  = 1'b0;
                    target_d = TARGET_TRACK;
                    settle_d = SETTLE_CNT;
                    recal_d  = CMD_RECAL;
                    seek_d   = !CMD_RECAL;
                    moved_d  = 1'b0;
                    state_d  = S_PLAN;
                end
            end
            S_PLAN: begin
                if (recal_q) begin
                    ctl_d   = 8'hFF;
                    pass_d  = 8'd0;
                    state_d = S_ISSUE;
                end else if (target_q > MAX_T) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else if (!valid_q) begin
                    recal_d = 1'b1;
                    ctl_d   = 8'hFF;
                    pass_d  = 8'd0;
                    state_d = S_ISSUE;
                end else if (diff_c == 8'd0) begin
                    // Only settle if the implicit recalibrate moved the head.
                    if (moved_q) begin
                        cnt_d   = settle_q;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    rem_d   = diff_c;
                    dir_d   = dir_c;
                    n_d     = plan_n_c;
                    ctl_d   = {dir_c, plan_field_c};
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_ARM;
            S_ARM:   state_d = S_WAIT;
            S_WAIT: begin
                if (!SC_IS_STEPPING) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (recal_q) begin
                    if (SC_TRACK0_HIT) begin
                        cur_d   = 8'd0;
                        valid_d = 1'b1;
                        recal_d = 1'b0;
                        if (seek_q) begin
                            moved_d = 1'b1;
                            state_d = S_PLAN;
                        end else begin
                            cnt_d   = settle_q;
                            state_d = S_SETTLE;
                        end
                    end else if ((pass_q + 8'd1) < PASSES) begin
                        pass_d  = pass_q + 8'd1;
                        state_d = S_ISSUE;
                    end else begin
                        valid_d = 1'b0;
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end
                end else if (dir_q && SC_TRACK0_HIT) begin
                    // Reached the stop early (or exactly): abandon the rest.
                    cur_d   = 8'd0;
                    error_d = (target_q != 8'd0);
                    cnt_d   = settle_q;
                    state_d = S_SETTLE;
                end else begin
                    cur_d = step_cur_c;
                    rem_d = rem_left_c;
                    if (rem_left_c == 8'd0) begin
                        cnt_d   = settle_q;
                        state_d = S_SETTLE;
                    end else begin
                        n_d     = next_n_c;
                        ctl_d   = {dir_q, next_field_c};
                        state_d = S_ISSUE;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q <= 16'd1) state_d = S_FINISH;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign write_d = (state_d == S_ISSUE);

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            recal_q  <= 1'b0;
            seek_q   <= 1'b0;
            moved_q  <= 1'b0;
            pass_q   <= 8'd0;
            target_q <= 8'd0;
            settle_q <= 16'd0;
            cnt_q    <= 16'd0;
            rem_q    <= 8'd0;
            dir_q    <= 1'b0;
            n_q      <= 8'd0;
            cur_q    <= 8'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            ctl_q    <= 8'h80;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            recal_q  <= recal_d;
            seek_q   <= seek_d;
            moved_q  <= moved_d;
            pass_q   <= pass_d;
            target_q <= target_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            n_q      <= n_d;
            cur_q    <= cur_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            ctl_q    <= ctl_d;
            write_q  <= write_d;
        end
    end

    assign BUSY        = (state_q != S_IDLE);
    assign DONE        = (state_q == S_FINISH);
    assign ERROR       = error_q;
    assign CUR_TRACK   = cur_q;
    assign TRACK_VALID = valid_q;
    assign SC_CTLBYTE  = ctl_q;
    assign SC_WRITE    = write_q;
endmodule

// File: tb/tb_seek_controller.sv
// Testbench for seek_controller: behavioural stepper/drive model, reference
// model of the command rules, and a scoreboard monitor checking on DONE.
module tb_seek_controller;
    localparam int MAX_TRACK    = 83;
    localparam int RECAL_PASSES = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CMD_SEEK = 1'b0;
    logic        CMD_RECAL = 1'b0;
    logic [7:0]  TARGET_TRACK = 8'd0;
    logic [15:0] SETTLE_CNT = 16'd0;
    logic        BUSY, DONE, ERROR, TRACK_VALID, SC_WRITE, SC_IS_STEPPING, SC_TRACK0_HIT;
    logic [7:0]  CUR_TRACK, SC_CTLBYTE;

    always #5 CLK = ~CLK;

    seek_controller #(.MAX_TRACK(MAX_TRACK), .RECAL_PASSES(RECAL_PASSES)) dut (
        .CLK(CLK), .RESET(RESET), .CMD_SEEK(CMD_SEEK), .CMD_RECAL(CMD_RECAL),
        .TARGET_TRACK(TARGET_TRACK), .SETTLE_CNT(SETTLE_CNT),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .CUR_TRACK(CUR_TRACK),
        .TRACK_VALID(TRACK_VALID), .SC_CTLBYTE(SC_CTLBYTE), .SC_WRITE(SC_WRITE),
        .SC_IS_STEPPING(SC_IS_STEPPING), .SC_TRACK0_HIT(SC_TRACK0_HIT)
    );

    // ---------------- stepper + drive model ----------------
    int phys_init = 0;
    bit stuck = 1'b0;
    int st_phys, st_cnt;
    bit st_arm, st_hit;

    function automatic int move(input int p, input logic [7:0] ctl);
        int steps;
        steps = int'(ctl[6:0]) + 1;
        if (ctl[7]) return (p > steps) ? p - steps : 0;
        return p + steps;
    endfunction

    assign SC_IS_STEPPING = (st_cnt != 0);
    assign SC_TRACK0_HIT  = st_hit;

    // Busy for a random few cycles per burst; hit flag appears one cycle after idle.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st_phys <= phys_init;
            st_cnt  <= 0;
            st_arm  <= 1'b0;
            st_hit  <= 1'b0;
        end else if (SC_WRITE) begin
            st_phys <= move(st_phys, SC_CTLBYTE);
            st_arm  <= SC_CTLBYTE[7] && (move(st_phys, SC_CTLBYTE) == 0) && !stuck;
            st_cnt  <= int'($urandom_range(5, 1));
            st_hit  <= 1'b0;
        end else begin
            if (st_cnt != 0) st_cnt <= st_cnt - 1;
            st_hit <= st_arm && (st_cnt == 0);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int err; int cur; int valid; int nwr; int kind; int delay;
    } exp_t;
    exp_t       exp_q[$];
    logic [7:0] ctl_q[$];

    int m_phys = 0, m_cur = 0, m_nwr = 0;
    bit m_valid = 1'b0;

    task automatic model_recal(output bit ok);
        ok = 1'b0;
        for (int p = 0; p < RECAL_PASSES && !ok; p++) begin
            ctl_q.push_back(8'hFF);
            m_nwr++;
            m_phys = (m_phys > 128) ? m_phys - 128 : 0;
            if (m_phys == 0 && !stuck) begin
                m_cur = 0; m_valid = 1'b1; ok = 1'b1;
            end
        end
        if (!ok) m_valid = 1'b0;
    endtask

    task automatic model_cmd(input bit is_recal, input int tgt, input int settle);
        exp_t e;
        bit   ok;
        int   rem, n;
        bit   dir;
        m_nwr  = 0;
        e.err  = 0;
        e.kind = 1;
        e.delay = ((settle == 0) ? 1 : settle) + 1;
        if (is_recal) begin
            model_recal(ok);
            e.err = ok ? 0 : 1;
            if (!ok) e.delay = 1;
        end else if (tgt > MAX_TRACK) begin
            e.err = 1; e.kind = 0; e.delay = 2;
        end else begin
            ok = 1'b1;
            if (!m_valid) model_recal(ok);
            if (!ok) begin
                e.err = 1; e.delay = 1;
            end else begin
                dir = (tgt < m_cur);
                rem = dir ? m_cur - tgt : tgt - m_cur;
                if (rem == 0) begin
                    e.kind = 0; e.delay = 2;
                end
                while (rem > 0) begin
                    n = (rem > 128) ? 128 : rem;
                    ctl_q.push_back({dir, 7'(n - 1)});
                    m_nwr++;
                    m_phys = dir ? ((m_phys > n) ? m_phys - n : 0) : m_phys + n;
                    if (dir && m_phys == 0 && !stuck) begin
                        m_cur = 0; e.err = (tgt != 0) ? 1 : 0; rem = 0;
                    end else begin
                        m_cur = dir ? m_cur - n : m_cur + n;
                        rem   = rem - n;
                    end
                end
            end
        end
        e.cur = m_cur; e.valid = m_valid ? 1 : 0; e.nwr = m_nwr;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, wr_total = 0;
    int accept_cyc = 0, last_chk = -1, watch_start = 0, nwr = 0;
    bit in_cmd = 1'b0, watch = 1'b0, after_done = 1'b0, rst_checked = 1'b0;
    exp_t       me;
    logic [7:0] ectl;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET) begin
                if (!rst_checked) begin
                    chk({BUSY, DONE, ERROR, SC_WRITE, TRACK_VALID, CUR_TRACK, SC_CTLBYTE} == 21'h00080,
                        "reset_values",
                        int'({BUSY, DONE, ERROR, SC_WRITE, TRACK_VALID, CUR_TRACK, SC_CTLBYTE}), 128);
                    rst_checked = 1'b1;
                end
                exp_q.delete();
                ctl_q.delete();
                in_cmd = 1'b0; watch = 1'b0; after_done = 1'b0;
            end else begin
                rst_checked = 1'b0;
                if (after_done) begin
                    chk(!BUSY, "busy_after_done", int'(BUSY), 0);
                    after_done = 1'b0;
                end
                if (!BUSY && (CMD_SEEK || CMD_RECAL)) begin
                    accept_cyc = cyc; in_cmd = 1'b1; nwr = 0; last_chk = -1; watch = 1'b0;
                end
                if (watch && cyc >= watch_start && !SC_IS_STEPPING) begin
                    last_chk = cyc + 1;
                    watch = 1'b0;
                end
                if (SC_WRITE) begin
                    wr_total++; nwr++; watch = 1'b1; watch_start = cyc + 2;
                    if (ctl_q.size() == 0) begin
                        chk(1'b0, "unexpected_write", int'(SC_CTLBYTE), -1);
                    end else begin
                        ectl = ctl_q.pop_front();
                        chk(SC_CTLBYTE == ectl, "ctlbyte", int'(SC_CTLBYTE), int'(ectl));
                    end
                end
                if (DONE) begin
                    done_cnt++;
                    after_done = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_done", 1, 0);
                    end else begin
                        me = exp_q.pop_front();
                        chk(BUSY == 1'b1, "busy_at_done", int'(BUSY), 1);
                        chk(int'(ERROR) == me.err, "error", int'(ERROR), me.err);
                        chk(int'(CUR_TRACK) == me.cur, "cur_track", int'(CUR_TRACK), me.cur);
                        chk(int'(TRACK_VALID) == me.valid, "track_valid", int'(TRACK_VALID), me.valid);
                        chk(nwr == me.nwr, "write_count", nwr, me.nwr);
                        if (me.kind == 0)
                            chk(cyc - accept_cyc == 2, "done_latency", cyc - accept_cyc, 2);
                        else
                            chk(last_chk >= 0 && cyc - last_chk == me.delay, "settle_latency",
                                cyc - last_chk, me.delay);
                        $display("cmd done @%0d: err=%0d cur=%0d valid=%0d writes=%0d",
                                 cyc, ERROR, CUR_TRACK, TRACK_VALID, nwr);
                    end
                    in_cmd = 1'b0;
                end else if (in_cmd && (cyc - accept_cyc) > 3000) begin
                    chk(1'b0, "done_timeout", cyc - accept_cyc, 3000);
                    in_cmd = 1'b0;
                    if (exp_q.size() > 0) me = exp_q.pop_front();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        phys_init = m_phys;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        m_valid = 1'b0;
        m_cur   = 0;
    endtask

    // junk > 0: pulse a CMD_SEEK junk cycles into the command (must be ignored).
    task automatic run_cmd(input bit rc, input bit sk, input int tgt, input int settle, input int junk);
        int d0;
        d0 = done_cnt;
        @(posedge CLK); #1;
        model_cmd(rc, tgt, settle);
        CMD_RECAL = rc; CMD_SEEK = sk;
        TARGET_TRACK = 8'(tgt); SETTLE_CNT = 16'(settle);
        @(posedge CLK); #1;
        CMD_RECAL = 1'b0; CMD_SEEK = 1'b0;
        if (junk > 0) begin
            repeat (junk - 1) @(posedge CLK);
            CMD_SEEK = 1'b1; TARGET_TRACK = 8'd10;
            @(posedge CLK); #1;
            CMD_SEEK = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge CLK);
    endtask

    initial begin
        int w0;
        @(posedge CLK); #1;
        do_reset();
        // Directed scenarios.
        run_cmd(1'b1, 1'b0, 0, 5, 0);      // recal at track 0 -> 0xFF, hit
        run_cmd(1'b0, 1'b1, 83, 10, 0);    // seek 83 -> 0x52
        run_cmd(1'b0, 1'b1, 0, 3, 0);      // seek 0 -> 0xD2, hit
        run_cmd(1'b0, 1'b1, 90, 4, 2);     // range error, junk pulse in DONE cycle
        run_cmd(1'b0, 1'b1, 83, 0, 0);     // back out to 83, zero settle
        run_cmd(1'b1, 1'b1, 50, 2, 0);     // both commands: recalibrate wins
        run_cmd(1'b0, 1'b1, 0, 1, 0);      // zero-distance seek
        m_phys = 20;
        do_reset();
        run_cmd(1'b0, 1'b1, 40, 4, 0);     // implicit recal then 0x27
        stuck = 1'b1;
        run_cmd(1'b1, 1'b0, 0, 7, 6);      // two 0xFF, fail; mid-command seek ignored
        // Reset during the second burst of a failing recalibrate.
        w0 = wr_total;
        @(posedge CLK); #1;
        model_cmd(1'b1, 0, 0);
        CMD_RECAL = 1'b1;
        @(posedge CLK); #1;
        CMD_RECAL = 1'b0;
        for (int i = 0; i < 200 && wr_total < w0 + 2; i++) @(posedge CLK);
        #1;
        do_reset();
        repeat (20) @(posedge CLK);
        stuck = 1'b0;
        // Randomized commands.
        for (int k = 0; k < 40; k++) begin
            int r, tgt, st, jk;
            bit rc, sk;
            r   = int'($urandom_range(9, 0));
            rc  = (r < 2);
            sk  = !rc || (r == 1);
            tgt = int'($urandom_range(95, 0));
            if (!m_valid && tgt == 0) tgt = 1;
            st  = int'($urandom_range(12, 0));
            jk  = (r == 9) ? int'($urandom_range(2, 1)) : 0;
            run_cmd(rc, sk, tgt, st, jk);
        end
        repeat (10) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
